// File: rtl/fc_neuron_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fc_neuron_stream
//  Purpose  : Sequential fully-connected neuron. Consumes a frame of IN signed
//             activation/weight pairs, P lanes per beat, accumulates the dot
//             product, adds a per-frame bias, applies optional ReLU and
//             presents one result on a valid/ready output.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             in_valid/in_ready - input beat handshake
//             in_x, in_w        - P packed signed activations / weights
//             bias, relu_en     - captured on the first beat of a frame
//             out_valid/out_ready/out_data - result handshake and value
//             busy              - frame in flight (first beat .. result taken)
//  Revision : 1.0 - initial release
// ============================================================================
module fc_neuron_stream #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int P     = 4,
  parameter int ACC_W = 2*WIDTH + $clog2(IN) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [P*WIDTH-1:0]        in_x,
  input  logic [P*WIDTH-1:0]        in_w,
  input  logic signed [2*WIDTH-1:0] bias,
  input  logic                      relu_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic                      busy
);

  localparam int NB     = IN / P;
  localparam int CW     = (NB > 1) ? $clog2(NB) : 1;
  // Sum of P products of 2*WIDTH bits each, plus a sign guard bit.
  localparam int PSUM_W = 2*WIDTH + $clog2(P) + 1;

  generate
    if ((IN % P) != 0) begin : g_bad_params
      $error("fc_neuron_stream: IN must be a multiple of P");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                   state, state_next;
  logic                     accept, cnt_last, finalize;
  logic [CW-1:0]            cnt;
  logic signed [PSUM_W-1:0] lane_sum, psum;
  logic                     psum_v, psum_first;
  logic signed [ACC_W-1:0]  acc, bias_q, result;
  logic                     relu_q;

  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt == CW'(NB - 1));
  // The final psum is in flight for one cycle after the last beat; once
  // psum_v drops in DRAIN, acc holds the complete dot product.
  assign finalize = (state == S_DRAIN) && !psum_v;
  assign result   = acc + bias_q;

  // Lane tree: P signed products summed combinationally.
  always_comb begin
    logic signed [2*WIDTH-1:0] prod;
    lane_sum = '0;
    prod     = '0;
    for (int k = 0; k < P; k++) begin
      prod     = $signed(in_x[k*WIDTH +: WIDTH]) * $signed(in_w[k*WIDTH +: WIDTH]);
      lane_sum = lane_sum + PSUM_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_valid is used directly in the branches (in_ready is 1 there) to keep
  // in_ready free of any combinational dependency on itself.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = cnt_last ? S_DRAIN : S_ACCUM;
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && cnt_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!psum_v) state_next = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      psum       <= '0;
      psum_v     <= 1'b0;
      psum_first <= 1'b0;
      acc        <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      out_data   <= '0;
    end else begin
      psum_v <= accept;
      if (accept) begin
        psum       <= lane_sum;
        psum_first <= (cnt == '0);
        cnt        <= cnt_last ? '0 : cnt + CW'(1);
      end
      if (accept && (state == S_IDLE)) begin
        bias_q <= ACC_W'(bias);
        relu_q <= relu_en;
      end
      // First psum of a frame overwrites, so no explicit clear is needed.
      if (psum_v) begin
        acc <= (psum_first ? ACC_W'(0) : acc) + ACC_W'(psum);
      end
      if (finalize) begin
        out_data <= (relu_q && result[ACC_W-1]) ? '0 : result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_neuron_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_neuron_stream
//  Purpose  : Directed self-checking bench for fc_neuron_stream with
//             WIDTH=8, IN=8, P=2 (NB=4, ACC_W=20).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_neuron_stream;

  localparam int WIDTH = 8;
  localparam int IN    = 8;
  localparam int P     = 2;
  localparam int ACC_W = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_x = '0;
  logic [15:0]       in_w = '0;
  logic signed [15:0] bias = '0;
  logic              relu_en = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_data;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  fc_neuron_stream #(.WIDTH(WIDTH), .IN(IN), .P(P), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .bias(bias), .relu_en(relu_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int ref_out(input logic [63:0] xs, input logic [63:0] ws,
                                 input logic signed [15:0] b, input bit r);
    int s;
    s = b;
    for (int i = 0; i < 8; i++) begin
      s += $signed(xs[i*8 +: 8]) * $signed(ws[i*8 +: 8]);
    end
    if (r && s < 0) s = 0;
    return s;
  endfunction

  task automatic toggle_side_inputs();
    bias    = 16'($urandom);
    relu_en = ~relu_en;
  endtask

  // Drives one 4-beat frame; lane k of beat b is element 2*b+k.
  task automatic drive_frame(input logic [63:0] xs, input logic [63:0] ws,
                             input logic [15:0] b, input bit r,
                             input int gap_max, input bit toggle);
    for (int k = 0; k < 4; k++) begin
      int idle;
      idle = (gap_max > 0) ? int'($urandom_range(gap_max, 1)) : 0;
      repeat (idle) begin
        in_valid = 1'b0;
        if (toggle && k > 0) toggle_side_inputs();
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_x = xs[k*16 +: 16];
      in_w = ws[k*16 +: 16];
      if (k == 0) begin
        bias = b; relu_en = r;
      end else if (toggle) begin
        toggle_side_inputs();
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_x = '0;
    in_w = '0;
    if (toggle) toggle_side_inputs();
  endtask

  task automatic wait_out(output int cyc, output bit timed_out);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    timed_out = !out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 20'd0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_frame({8{8'd1}}, {8{8'd3}}, 16'd0, 1'b1, 0, 1'b0);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_in_ready_drop: got %b expected 0", in_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_early: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_latency: got %b expected 1", out_valid); end
    n_checks++; if (out_data !== 20'd24) begin n_fail++; $display("FAIL basic_data: got %0d expected 24", out_data); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_pulse: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_back: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    n_checks++; if (out_data !== 20'd24) begin n_fail++; $display("FAIL basic_data_kept: got %0d expected 24", out_data); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to;
    // Starts the cycle right after the previous handshake.
    drive_frame({8{8'd2}}, {8{8'd3}}, 16'd1, 1'b0, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || cyc != 2) begin n_fail++; $display("FAIL b2b_latency: got %0d cycles (timeout %b) expected 2", cyc, to); end
    n_checks++; if (out_data !== 20'd49) begin n_fail++; $display("FAIL b2b_data: got %0d expected 49", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_relu();
    int cyc; bit to;
    drive_frame({8{8'd1}}, {8{8'hFD}}, 16'd5, 1'b1, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== 20'd0) begin n_fail++; $display("FAIL relu_on: got %0h (timeout %b) expected 0", out_data, to); end
    @(posedge clk); #1;
    drive_frame({8{8'd1}}, {8{8'hFD}}, 16'd5, 1'b0, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== 20'hFFFED) begin n_fail++; $display("FAIL relu_off: got %0h (timeout %b) expected fffed", out_data, to); end
    @(posedge clk); #1;
  endtask

  task automatic test_extremes();
    int cyc; bit to;
    drive_frame({8{8'h80}}, {8{8'h80}}, 16'h7FFF, 1'b1, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== 20'h27FFF) begin n_fail++; $display("FAIL extreme_pos: got %0h (timeout %b) expected 27fff", out_data, to); end
    @(posedge clk); #1;
    drive_frame({8{8'h7F}}, {8{8'h80}}, 16'h8000, 1'b0, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== 20'hD8400) begin n_fail++; $display("FAIL extreme_neg: got %0h (timeout %b) expected d8400", out_data, to); end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps_stall();
    int cyc; bit to;
    logic [63:0] xs, ws;
    logic [15:0] b;
    logic [ACC_W-1:0] exp_v, hold;
    out_ready = 1'b0;
    xs = {$urandom, $urandom};
    ws = {$urandom, $urandom};
    b  = 16'($urandom);
    exp_v = ACC_W'(ref_out(xs, ws, b, 1'b0));
    drive_frame(xs, ws, b, 1'b0, 3, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== exp_v) begin n_fail++; $display("FAIL gaps_data: got %0h (timeout %b) expected %0h", out_data, to, exp_v); end
    hold = out_data;
    repeat (5) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
      n_checks++; if (out_data !== hold) begin n_fail++; $display("FAIL stall_data: got %0h expected %0h", out_data, hold); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got valid %b ready %b expected 0 1", out_valid, in_ready); end
    xs = {$urandom, $urandom};
    ws = {$urandom, $urandom};
    b  = 16'($urandom);
    exp_v = ACC_W'(ref_out(xs, ws, b, 1'b1));
    drive_frame(xs, ws, b, 1'b1, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== exp_v) begin n_fail++; $display("FAIL gaps_next_frame: got %0h (timeout %b) expected %0h", out_data, to, exp_v); end
    @(posedge clk); #1;
    // Leave a known non-zero result behind for the reset check.
    drive_frame({8{8'd1}}, {8{8'd1}}, 16'd0, 1'b0, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== 20'd8) begin n_fail++; $display("FAIL ones_frame: got %0d (timeout %b) expected 8", out_data, to); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int cyc; bit to;
    in_valid = 1'b1; in_x = {2{8'd100}}; in_w = {2{8'd100}}; bias = 16'd7; relu_en = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 20'd0) begin n_fail++; $display("FAIL midrst_out_data: got %0h expected 0", out_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    drive_frame({8{8'd2}}, {8{8'd2}}, 16'hFFFF, 1'b0, 0, 1'b0);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== 20'd31) begin n_fail++; $display("FAIL midrst_next_frame: got %0d (timeout %b) expected 31", out_data, to); end
    @(posedge clk); #1;
  endtask

  task automatic test_capture();
    int cyc; bit to;
    drive_frame({8{8'd1}}, {8{8'hFD}}, 16'd10, 1'b0, 1, 1'b1);
    wait_out(cyc, to);
    n_checks++; if (to || out_data !== 20'hFFFF2) begin n_fail++; $display("FAIL capture_first_beat: got %0h (timeout %b) expected ffff2", out_data, to); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL capture_handshake: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_relu();
    test_extremes();
    test_gaps_stall();
    test_reset_mid();
    test_capture();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fc_neuron_stream.md
# fc_neuron_stream

Sequential, parametrised fully-connected neuron for the CNN inference datapath. Consumes a frame of `IN` signed activation/weight pairs as a valid/ready stream, `P` lanes per beat. Accumulates the dot product, adds a per-frame bias and applies an optional ReLU, then presents one result on a valid/ready output.
- Generalises the fixed-coefficient, fully unrolled FC layer: runtime weights, selectable parallelism, runtime ReLU enable.
- Sits between the feature-map buffer and the classifier output register.

## Interface
- `WIDTH`, 8: activation and weight width; signed two's complement.
- `IN`, 128: products per frame. Must be a multiple of `P`; otherwise elaboration fails.
- `P`, 4: lanes per beat. Beats per frame `NB = IN/P`.
- `ACC_W`, `2*WIDTH+$clog2(IN)+1`: accumulator and output width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: block can accept a beat.
- `in_x` in `P*WIDTH`: activations; lane k at bits `[k*WIDTH +: WIDTH]`.
- `in_w` in `P*WIDTH`: weights, same lane packing.
- `bias` in `2*WIDTH`: signed bias.
- `relu_en` in 1: 1 clamps negative results to 0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `out_data` out `ACC_W`: signed result; non-negative when `relu_en` was 1.
- `busy` out 1: high from first-beat acceptance until result handshake.

## Operation
- Beat accepted on any edge with `in_valid && in_ready`.
- On the first accepted beat of a frame, `bias` (sign-extended to `ACC_W`) and `relu_en` are captured. Later changes to these inputs within the frame are ignored.
- Stage 1: P signed products `2*WIDTH` wide, summed by a combinational lane tree, registered as `psum` with a `psum_v` flag.
- Stage 2: `acc <= (first ? 0 : acc) + sext(psum)` when `psum_v`. The first psum of a frame overwrites the accumulator instead of adding to it.
- Beat counter `0..NB-1` wraps to 0 on the last beat. No in-band last signal; framing is purely by count.
- Finalise: `r = acc + bias_q`; `out_data <= (relu_q && r<0) ? 0 : r`. Full width, no truncation. `ACC_W` guarantees no overflow for any inputs.
- FSM states:
  - IDLE: `in_ready=1`. First beat → ACCUM.
  - ACCUM: `in_ready=1`. Last beat (counter `NB-1`) → DRAIN.
  - DRAIN: `in_ready=0`. Waits for the final psum to be accumulated, then finalises → OUT.
  - OUT: `in_ready=0`, `out_valid=1`. `out_ready` → IDLE.
- If `NB==1`, the first beat is also the last: IDLE → DRAIN directly.
- `in_valid` gaps in ACCUM are legal. Counter, acc and psum hold; `psum_v` is 0 for idle cycles.
- Frames do not overlap. The next frame's first beat is accepted no earlier than the cycle after the output handshake.

## Timing
- Reset (async assert, sync-safe deassert) clears:
  - state=IDLE, counter=0, `psum_v=0`, `acc=0`
  - outputs: `out_valid=0`, `out_data=0`, `busy=0`, `in_ready=1`
- Reset mid-frame discards all partial state. No output is produced for the aborted frame.
- Latency: last beat accepted at edge E0 → acc final at E1 → `out_valid=1` and `out_data` registered at E2. `out_valid` is visible in the cycle after E2.
- `in_ready` falls in the cycle after E0 and stays low through DRAIN and OUT.
- `out_data` and `out_valid` hold stable while `out_ready=0`.
- Output handshake edge H: `out_valid=0` and `in_ready=1` after H. `out_data` keeps its last value.
- `out_ready` high while `out_valid=0` has no effect.
- `busy` rises after the first-beat edge and falls after H.
- Minimum frame period: `NB+3` cycles with `out_ready` tied high.

## Test plan
Configuration for all tests: `WIDTH=8`, `IN=8`, `P=2`, so `NB=4` and `ACC_W=20`.
- All x=1, w=3, bias=0, relu_en=1, back-to-back beats, `out_ready=1` → `out_data=24`. `out_valid` 2 cycles after the last beat edge, high for 1 cycle.
- x=1, w=-3, bias=5 → `relu_en=1` gives 0; repeat with `relu_en=0` gives -19 (`20'hFFFED`).
- All x=-128, w=-128, bias=32767 → 131072+32767=163839. Then all x=127, w=-128, bias=-32768 → -130048-32768=-162816. No wrap.
- Random `in_valid` gaps (≥50% idle) plus `out_ready` held low 5 cycles: result matches a reference dot product, `out_data` stable while stalled, `in_ready=0` throughout, next frame correct.
- `rst_n` pulsed low mid-cycle after 2 beats: all outputs take reset values immediately. A following full frame (x=2, w=2, bias=-1) gives 31, with no leakage of earlier partial sums.
- bias and relu_en toggled every cycle after the first beat: result uses only the first-beat values.
